// File: rtl/gb_video_pkg.sv
// Shared constants, pixel type and window placement helper for the
// Game Boy 640x480 HDMI video path.
package gb_video_pkg;

    localparam int GB_H_ACTIVE = 640;
    localparam int GB_H_FP     = 16;
    localparam int GB_H_SYNC   = 96;
    localparam int GB_H_BP     = 48;
    localparam int GB_V_ACTIVE = 480;
    localparam int GB_V_FP     = 10;
    localparam int GB_V_SYNC   = 2;
    localparam int GB_V_BP     = 33;
    localparam int GB_WIDTH    = 160;
    localparam int GB_HEIGHT   = 144;
    localparam int GB_SCALE    = 3;
    localparam int GB_LATENCY  = 3;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    // Origin of an upscaled frame centred inside an active span.
    function automatic int win_origin(input int active, input int size, input int scale);
        return (active - size * scale) / 2;
    endfunction

endpackage

// File: rtl/gb_video_timing_pipe.sv
// N-stage register shift line used to carry raster timing flags across the
// framebuffer/palette read latency.
module pipe_delay #(
    parameter int             W         = 1,
    parameter int             N         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clock25,
    input  logic         resetn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [N];

    // Shift the input through N stages; reset loads the inactive value.
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) r_stage[i] <= RESET_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[N-1];

endmodule

// File: rtl/gb_video_timing.sv
// 640x480@60 raster generator that centres an integer-upscaled Game Boy
// frame, issues framebuffer coordinates and drives the HDMI transmitter.
module gb_video_timing
    import gb_video_pkg::*;
#(
    parameter int          H_ACTIVE = GB_H_ACTIVE,
    parameter int          H_FP     = GB_H_FP,
    parameter int          H_SYNC   = GB_H_SYNC,
    parameter int          H_BP     = GB_H_BP,
    parameter int          V_ACTIVE = GB_V_ACTIVE,
    parameter int          V_FP     = GB_V_FP,
    parameter int          V_SYNC   = GB_V_SYNC,
    parameter int          V_BP     = GB_V_BP,
    parameter int          WIDTH    = GB_WIDTH,
    parameter int          HEIGHT   = GB_HEIGHT,
    parameter int          SCALE    = GB_SCALE,
    parameter int          LATENCY  = GB_LATENCY,
    parameter logic [23:0] BORDER   = 24'h000000
) (
    input  logic        clock25,
    input  logic        resetn,
    output logic [7:0]  x,
    output logic [7:0]  y,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        frame_start,
    output logic        HDMI_TX_CLK,
    output logic [23:0] HDMI_TX_D,
    output logic        HDMI_TX_DE,
    output logic        HDMI_TX_HS,
    output logic        HDMI_TX_VS,
    input  logic        HDMI_TX_INT
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X0      = win_origin(H_ACTIVE, WIDTH, SCALE);
    localparam int Y0      = win_origin(V_ACTIVE, HEIGHT, SCALE);

    localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] C_X0     = 10'(X0);
    localparam logic [9:0] C_X1     = 10'(X0 + WIDTH * SCALE);
    localparam logic [9:0] C_Y0     = 10'(Y0);
    localparam logic [9:0] C_Y1     = 10'(Y0 + HEIGHT * SCALE);
    localparam logic [7:0] C_S_LAST = 8'(SCALE - 1);

    logic [9:0]  r_hcount, r_vcount;
    logic [7:0]  r_x, r_subx, r_y, r_yrow, r_suby;
    logic [23:0] r_tx_d;
    logic        r_de, r_hs, r_vs;

    logic [9:0]  w_h_next, w_v_next;
    logic        w_h_wrap, w_win_next, w_row_in;
    logic [7:0]  w_x_next, w_subx_next, w_yrow_next, w_suby_next;
    logic        w_de_raw, w_hs_raw, w_vs_raw, w_win_raw;
    logic [3:0]  w_pipe;
    rgb888_t     w_pix;
    logic        w_unused_int;

    // Next raster position and next-cycle coordinate state. Coordinates are
    // computed for the upcoming position so that the registered x/y line up
    // with hcount/vcount in the same cycle.
    always_comb begin
        w_h_wrap    = (r_hcount == C_H_LAST);
        w_h_next    = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        w_v_next    = r_vcount;
        if (w_h_wrap) w_v_next = (r_vcount == C_V_LAST) ? 10'd0 : r_vcount + 10'd1;
        w_win_next  = (w_h_next >= C_X0) && (w_h_next < C_X1) &&
                      (w_v_next >= C_Y0) && (w_v_next < C_Y1);
        w_row_in    = (r_vcount >= C_Y0) && (r_vcount < C_Y1);

        w_x_next    = 8'd0;
        w_subx_next = 8'd0;
        if (w_win_next && (w_h_next != C_X0)) begin
            if (r_subx == C_S_LAST) begin
                w_x_next = r_x + 8'd1;
            end else begin
                w_x_next    = r_x;
                w_subx_next = r_subx + 8'd1;
            end
        end

        w_yrow_next = r_yrow;
        w_suby_next = r_suby;
        if (w_h_wrap) begin
            if (w_v_next == C_Y0) begin
                w_yrow_next = 8'd0;
                w_suby_next = 8'd0;
            end else if (w_row_in) begin
                if (r_suby == C_S_LAST) begin
                    w_yrow_next = r_yrow + 8'd1;
                    w_suby_next = 8'd0;
                end else begin
                    w_suby_next = r_suby + 8'd1;
                end
            end
        end
    end

    assign w_de_raw  = (r_hcount < C_H_ACT) && (r_vcount < C_V_ACT);
    assign w_hs_raw  = !((r_hcount >= C_HS_BEG) && (r_hcount < C_HS_END));
    assign w_vs_raw  = !((r_vcount >= C_VS_BEG) && (r_vcount < C_VS_END));
    assign w_win_raw = (r_hcount >= C_X0) && (r_hcount < C_X1) &&
                       (r_vcount >= C_Y0) && (r_vcount < C_Y1);

    // Raster counters and coordinate registers.
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_x      <= '0;
            r_subx   <= '0;
            r_y      <= '0;
            r_yrow   <= '0;
            r_suby   <= '0;
        end else begin
            r_hcount <= w_h_next;
            r_vcount <= w_v_next;
            r_x      <= w_x_next;
            r_subx   <= w_subx_next;
            r_y      <= w_win_next ? w_yrow_next : 8'd0;
            r_yrow   <= w_yrow_next;
            r_suby   <= w_suby_next;
        end
    end

    pipe_delay #(
        .W         (4),
        .N         (LATENCY),
        .RESET_VAL (4'b0110)
    ) u_timing_pipe (
        .clock25 (clock25),
        .resetn  (resetn),
        .i_d     ({w_de_raw, w_hs_raw, w_vs_raw, w_win_raw}),
        .o_q     (w_pipe)
    );

    assign w_pix = '{red: r, green: g, blue: b};

    // Output stage: pixel data, border or blanking, with sync and DE.
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            r_tx_d <= '0;
            r_de   <= 1'b0;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
        end else begin
            r_de   <= w_pipe[3];
            r_hs   <= w_pipe[2];
            r_vs   <= w_pipe[1];
            if (w_pipe[3] && w_pipe[0]) r_tx_d <= w_pix;
            else if (w_pipe[3])         r_tx_d <= BORDER;
            else                        r_tx_d <= '0;
        end
    end

    // frame_start is undelayed: high while the raster sits at the origin,
    // but never while held in reset.
    assign frame_start  = resetn && (r_hcount == 10'd0) && (r_vcount == 10'd0);
    assign x            = r_x;
    assign y            = r_y;
    assign HDMI_TX_CLK  = ~clock25;
    assign HDMI_TX_D    = r_tx_d;
    assign HDMI_TX_DE   = r_de;
    assign HDMI_TX_HS   = r_hs;
    assign HDMI_TX_VS   = r_vs;
    assign w_unused_int = HDMI_TX_INT;

endmodule

// File: tb/tb_gb_video_timing.sv
// Directed bench for gb_video_timing. Horizontal timing is the real 800-cycle
// line; the vertical raster is shortened so whole frames stay short.
module tb_gb_video_timing;

    localparam int HA = 640, HFP = 16, HSY = 96, HBP = 48;
    localparam int VA = 20,  VFP = 2,  VSY = 2,  VBP = 2;
    localparam int WID = 160, HEI = 6, SC = 3, LAT = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int X0 = (HA - WID * SC) / 2;
    localparam int Y0 = (VA - HEI * SC) / 2;
    localparam logic [23:0] BRD = 24'h102030;

    logic        clock25 = 1'b0;
    logic        resetn  = 1'b0;
    logic [7:0]  gb_x, gb_y;
    logic [7:0]  pr, pg, pb;
    logic        fs;
    logic        tx_clk, tx_de, tx_hs, tx_vs;
    logic [23:0] tx_d;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;
    int fs_last = 0;
    int fs_period = 0;
    bit fs_seen = 0;

    logic [7:0] px1 = 0, px2 = 0, px3 = 0;
    logic [7:0] py1 = 0, py2 = 0, py3 = 0;

    gb_video_timing #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .WIDTH (WID), .HEIGHT (HEI), .SCALE (SC), .LATENCY (LAT),
        .BORDER (BRD)
    ) dut (
        .clock25     (clock25),
        .resetn      (resetn),
        .x           (gb_x),
        .y           (gb_y),
        .r           (pr),
        .g           (pg),
        .b           (pb),
        .frame_start (fs),
        .HDMI_TX_CLK (tx_clk),
        .HDMI_TX_D   (tx_d),
        .HDMI_TX_DE  (tx_de),
        .HDMI_TX_HS  (tx_hs),
        .HDMI_TX_VS  (tx_vs),
        .HDMI_TX_INT (1'b0)
    );

    always #20 clock25 = ~clock25;

    // Framebuffer/palette model: r=x, g=y, b=5A, three cycles after x/y.
    always @(posedge clock25) begin
        px1 <= gb_x; px2 <= px1; px3 <= px2;
        py1 <= gb_y; py2 <= py1; py3 <= py2;
    end
    assign pr = px3;
    assign pg = py3;
    assign pb = 8'h5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (n=%0d): observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    function automatic bit m_win(input int h, input int v);
        return (h >= X0) && (h < X0 + WID * SC) && (v >= Y0) && (v < Y0 + HEI * SC);
    endfunction

    task automatic check_all();
        int pos, h, v, p, hp, vp;
        logic [23:0] ed;
        pos = n % FRAME; h = pos % HT; v = pos / HT;
        chk("frame_start", fs, pos == 0);
        chk("x", gb_x, m_win(h, v) ? (h - X0) / SC : 0);
        chk("y", gb_y, m_win(h, v) ? (v - Y0) / SC : 0);
        chk("tx_clk", tx_clk, 1);
        if (n < LAT + 1) begin
            chk("d_lead", tx_d, 0);
            chk("de_lead", tx_de, 0);
            chk("hs_lead", tx_hs, 1);
            chk("vs_lead", tx_vs, 1);
        end else begin
            p = (n - LAT - 1) % FRAME; hp = p % HT; vp = p / HT;
            if (hp < HA && vp < VA) ed = m_win(hp, vp) ? {8'((hp - X0) / SC), 8'((vp - Y0) / SC), 8'h5A} : BRD;
            else ed = 24'h0;
            chk("data", tx_d, ed);
            chk("de", tx_de, (hp < HA) && (vp < VA));
            chk("hs", tx_hs, !((hp >= HA + HFP) && (hp < HA + HFP + HSY)));
            chk("vs", tx_vs, !((vp >= VA + VFP) && (vp < VA + VFP + VSY)));
        end
        if (fs === 1'b1) begin
            if (fs_seen) fs_period = n - fs_last;
            fs_last = n;
            fs_seen = 1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hcount"}, dut.r_hcount, 0);
        chk({tag, "_vcount"}, dut.r_vcount, 0);
        chk({tag, "_subx"}, dut.r_subx, 0);
        chk({tag, "_suby"}, dut.r_suby, 0);
        chk({tag, "_x"}, gb_x, 0);
        chk({tag, "_y"}, gb_y, 0);
        chk({tag, "_fs"}, fs, 0);
        chk({tag, "_d"}, tx_d, 0);
        chk({tag, "_de"}, tx_de, 0);
        chk({tag, "_hs"}, tx_hs, 1);
        chk({tag, "_vs"}, tx_vs, 1);
    endtask

    task automatic tick();
        @(negedge clock25);
        #1;
        n++;
        check_all();
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic release_reset();
        @(negedge clock25);
        resetn = 1'b1;
        n = 0;
        fs_seen = 0;
        fs_period = 0;
        #1;
        check_all();
    endtask

    initial begin
        int de_cnt, hs_cnt, vs_cnt;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock25);
            #1;
            chk_reset("reset");
        end
        release_reset();
        chk("fs_first_cycle", fs, 1);
        tick();
        chk("hcount_after_release", dut.r_hcount, 1);

        run_to(HA + HFP + LAT);
        chk("hs_before_fall", tx_hs, 1);
        tick();
        chk("hs_fall", tx_hs, 0);
        run_to(HA + HFP + HSY + LAT);
        chk("hs_before_rise", tx_hs, 0);
        tick();
        chk("hs_rise", tx_hs, 1);

        run_to(Y0 * HT + X0);
        chk("x_col0_a", gb_x, 0);
        tick(); chk("x_col0_b", gb_x, 0);
        tick(); chk("x_col0_c", gb_x, 0);
        tick(); chk("x_col1", gb_x, 1);
        run_to(Y0 * HT + X0 + 159 * SC);
        chk("x_last_a", gb_x, 159);
        run_to(Y0 * HT + X0 + 160 * SC - 1);
        chk("x_last_c", gb_x, 159);
        tick(); chk("x_after_window", gb_x, 0);

        run_to(2 * HT - 1);
        de_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < HT; i++) begin
            tick();
            if (tx_de) de_cnt++;
            if (!tx_hs) hs_cnt++;
        end
        chk("de_per_line", de_cnt, HA);
        chk("hs_low_per_line", hs_cnt, HSY);

        run_to((Y0 + 2) * HT + 100); chk("y_row0_last_line", gb_y, 0);
        run_to((Y0 + 3) * HT + 100); chk("y_row1", gb_y, 1);
        run_to((Y0 + HEI * SC - 1) * HT + 100); chk("y_last_row", gb_y, HEI - 1);
        run_to((Y0 + HEI * SC) * HT + 100); chk("y_below_window", gb_y, 0);

        run_to(VA * HT - 1);
        de_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < (VT - VA) * HT; i++) begin
            tick();
            if (tx_de) de_cnt++;
            if (!tx_vs) vs_cnt++;
        end
        chk("de_in_vblank", de_cnt, 0);
        chk("vs_low_cycles", vs_cnt, VSY * HT);

        run_to(FRAME);
        chk("fs_second_frame", fs, 1);
        chk("frame_period", fs_period, FRAME);

        run_to(FRAME + 10 * HT + 300);
        resetn = 1'b0;
        #1;
        chk_reset("midreset0");
        for (int i = 0; i < 2; i++) begin
            @(negedge clock25);
            #1;
            chk_reset("midreset");
        end
        release_reset();
        chk("fs_after_midreset", fs, 1);
        run_to(FRAME);
        chk("frame_period_after_reset", fs_period, FRAME);
        run_to(FRAME + HT + 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
